// File: rtl/hdegen_prog.sv
// Programmable horizontal display-enable generator.
// Counter, visible/DE windows with scroll delay and register file.
module hdegen_prog #(
    parameter int CW  = 8,
    parameter int SDW = 3
) (
    input  logic          m2clock,
    input  logic          porb,
    input  logic          ihsync,
    input  logic          vblank,
    input  logic          vde,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic [2:0]    rd_addr,
    output logic [CW-1:0] rd_data,
    output logic [CW-1:0] hcount,
    output logic          hde1,
    output logic          blank_n,
    output logic          de
);

    localparam int MAXD = (1 << SDW) - 1;

    logic [CW-1:0]   hvis_start;
    logic [CW-1:0]   hvis_end;
    logic [CW-1:0]   hde_start;
    logic [CW-1:0]   hde_end;
    logic [CW-1:0]   hmax;
    logic [SDW-1:0]  scroll_dly;
    logic            hvis;
    logic            hde;
    logic [MAXD-1:0] pipe;
    logic [MAXD-1:0] pipe_n;
    logic            hde_hit;
    logic            hde_set;

    // A start match is injected at tap D-1 so it emerges after D shifts;
    // in-flight bits keep the delay they were injected with.
    always_comb begin
        hde_hit = (hcount == hde_start);
        pipe_n  = pipe >> 1;
        for (int i = 0; i < MAXD; i++) begin
            if (hde_hit && scroll_dly == SDW'(i + 1)) begin
                pipe_n[i] = 1'b1;
            end
        end
        hde_set = pipe[0] | (hde_hit && scroll_dly == '0);
    end

    always_ff @(posedge m2clock or negedge porb) begin
        if (!porb) begin
            hvis_start <= CW'(9);
            hvis_end   <= CW'(114);
            hde_start  <= CW'(12);
            hde_end    <= CW'(96);
            hmax       <= '1;
            scroll_dly <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                3'd0:    hvis_start <= wr_data;
                3'd1:    hvis_end   <= wr_data;
                3'd2:    hde_start  <= wr_data;
                3'd3:    hde_end    <= wr_data;
                3'd4:    hmax       <= wr_data;
                3'd5:    scroll_dly <= wr_data[SDW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge m2clock or negedge porb) begin
        if (!porb) begin
            hcount <= '0;
            hvis   <= 1'b0;
            hde    <= 1'b0;
            pipe   <= '0;
        end else if (ihsync) begin
            hcount <= '0;
            hvis   <= 1'b0;
            hde    <= 1'b0;
            pipe   <= '0;
        end else begin
            hcount <= (hcount == hmax) ? '0 : hcount + 1'b1;
            pipe   <= pipe_n;
            if (hcount == hvis_end) begin
                hvis <= 1'b0;
            end else if (hcount == hvis_start) begin
                hvis <= 1'b1;
            end
            if (hcount == hde_end) begin
                hde <= 1'b0;
            end else if (hde_set) begin
                hde <= 1'b1;
            end
        end
    end

    always_ff @(posedge m2clock or negedge porb) begin
        if (!porb) begin
            hde1    <= 1'b0;
            blank_n <= 1'b1;
            de      <= 1'b1;
        end else begin
            hde1    <= hde;
            blank_n <= hvis & vblank;
            de      <= hde & vde;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            3'd0:    rd_data = hvis_start;
            3'd1:    rd_data = hvis_end;
            3'd2:    rd_data = hde_start;
            3'd3:    rd_data = hde_end;
            3'd4:    rd_data = hmax;
            3'd5:    rd_data = CW'(scroll_dly);
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_hdegen_prog.sv
// Scoreboard bench for hdegen_prog: timestamp-based reference model
// feeds an expected-output queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_hdegen_prog;

    localparam int CW  = 8;
    localparam int SDW = 3;

    logic          m2clock = 1'b0;
    logic          porb;
    logic          ihsync;
    logic          vblank;
    logic          vde;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [CW-1:0] wr_data;
    logic [2:0]    rd_addr;
    logic [CW-1:0] rd_data;
    logic [CW-1:0] hcount;
    logic          hde1;
    logic          blank_n;
    logic          de;

    hdegen_prog #(.CW(CW), .SDW(SDW)) dut (
        .m2clock(m2clock),
        .porb(porb),
        .ihsync(ihsync),
        .vblank(vblank),
        .vde(vde),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .hcount(hcount),
        .hde1(hde1),
        .blank_n(blank_n),
        .de(de)
    );

    always #10 m2clock = ~m2clock;

    typedef struct packed {
        logic [CW-1:0] hc;
        logic          hde1;
        logic          blank_n;
        logic          de;
    } exp_t;

    exp_t   expq[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model: windows as booleans, delayed sets as absolute due times.
    int     regs[8];
    int     m_hc;
    bit     m_hvis;
    bit     m_hde;
    longint pend[$];
    longint cyc = 0;

    function automatic void model_reset();
        regs[0] = 9;
        regs[1] = 114;
        regs[2] = 12;
        regs[3] = 96;
        regs[4] = (1 << CW) - 1;
        regs[5] = 0;
        regs[6] = 0;
        regs[7] = 0;
        m_hc    = 0;
        m_hvis  = 0;
        m_hde   = 0;
        pend.delete();
    endfunction

    always @(posedge m2clock) begin : model
        exp_t e;
        bit   set;
        int   d;
        cyc++;
        if (!porb) begin
            model_reset();
            e.hc      = '0;
            e.hde1    = 1'b0;
            e.blank_n = 1'b1;
            e.de      = 1'b1;
        end else begin
            e.hde1    = m_hde;
            e.blank_n = m_hvis & vblank;
            e.de      = m_hde & vde;
            if (ihsync) begin
                m_hc   = 0;
                m_hvis = 0;
                m_hde  = 0;
                pend.delete();
            end else begin
                set = 0;
                d   = regs[5];
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (pend[i] == cyc) begin
                        set = 1;
                        pend.delete(i);
                    end
                end
                if (m_hc == regs[2]) begin
                    if (d == 0) set = 1;
                    else pend.push_back(cyc + longint'(d));
                end
                if (m_hc == regs[3]) m_hde = 0;
                else if (set) m_hde = 1;
                if (m_hc == regs[1]) m_hvis = 0;
                else if (m_hc == regs[0]) m_hvis = 1;
                m_hc = (m_hc == regs[4]) ? 0 : (m_hc + 1) % (1 << CW);
            end
            if (wr_en && wr_addr < 3'd6) begin
                regs[wr_addr] = (wr_addr == 3'd5) ? int'(wr_data) % (1 << SDW)
                                                  : int'(wr_data);
            end
            e.hc = CW'(m_hc);
        end
        expq.push_back(e);
    end

    always @(negedge m2clock) begin : monitor
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if ({hcount, hde1, blank_n, de} !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got hc=%0d hde1=%b blank_n=%b de=%b want hc=%0d hde1=%b blank_n=%b de=%b",
                         $time, hcount, hde1, blank_n, de, e.hc, e.hde1, e.blank_n, e.de);
            end
        end
    end

    task automatic tick();
        @(negedge m2clock);
        #2;
        n_cmp++;
        if (rd_data !== CW'(regs[rd_addr])) begin
            n_bad++;
            $display("FAIL readback addr=%0d got %0d want %0d", rd_addr, rd_data, regs[rd_addr]);
        end
    endtask

    task automatic wr(input int a, input int v);
        tick();
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = CW'(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic hsync_pulse();
        tick();
        ihsync = 1'b1;
        tick();
        ihsync = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rd_addr = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic check_now(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    initial begin
        porb    = 1'b0;
        ihsync  = 1'b0;
        vblank  = 1'b1;
        vde     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) tick();
        porb = 1'b1;

        hsync_pulse();
        run(300);

        for (int i = 0; i < 3000; i++) begin
            tick();
            ihsync  = ($urandom_range(0, 149) == 0);
            vblank  = ($urandom_range(0, 7) != 0);
            vde     = ($urandom_range(0, 7) != 0);
            wr_en   = ($urandom_range(0, 19) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = CW'($urandom);
            if (wr_addr == 3'd4 && wr_data < CW'(40)) wr_data = wr_data + CW'(60);
            rd_addr = 3'($urandom_range(0, 7));
        end
        tick();
        ihsync = 1'b0;
        wr_en  = 1'b0;
        vblank = 1'b1;
        vde    = 1'b1;

        wr(0, 20);
        wr(1, 20);
        wr(2, 20);
        wr(3, 20);
        wr(5, 0);
        wr(4, 127);
        wr(6, 55);
        wr(7, 66);
        run(300);

        wr(0, 9);
        wr(1, 114);
        wr(2, 12);
        wr(3, 96);
        wr(5, 5);
        hsync_pulse();
        run(200);
        wr(5, 2);
        run(200);

        for (int k = 0; k < 4; k++) begin
            run($urandom_range(20, 120));
            tick();
            rd_addr = 3'd0;
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = CW'(200);
            porb    = 1'b0;
            #1;
            check_now("rst_hcount", hcount, '0);
            check_now("rst_hde1", CW'(hde1), '0);
            check_now("rst_blank_n", CW'(blank_n), CW'(1));
            check_now("rst_de", CW'(de), CW'(1));
            check_now("rst_rd_hvis_start", rd_data, CW'(9));
            for (int a = 0; a < 8; a++) begin
                tick();
                rd_addr = 3'(a);
            end
            tick();
            wr_en = 1'b0;
            porb  = 1'b1;
            if (k[0]) hsync_pulse();
        end

        run(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
